// File: rtl/insmem_arbiter.sv
// Arbiter and sequencer for the single-port 128x32 instruction memory.
// Fetch and loader requests are served round-robin through an IDLE/ACCESS/RESP sequence.
module insmem_arbiter #(
  parameter int DEPTH = 128,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_req,
  input  logic [6:0]       fetch_addr,
  output logic             fetch_gnt,
  output logic             fetch_valid,
  output logic [31:0]      fetch_data,
  input  logic             load_req,
  input  logic [6:0]       load_addr,
  input  logic [31:0]      load_data,
  output logic             load_gnt,
  output logic             load_done,
  output logic             addr_err,
  output logic [6:0]       mem_addr,
  output logic [31:0]      mem_datain,
  output logic             mem_sigwr,
  output logic             mem_sigon,
  input  logic [31:0]      mem_dataout,
  output logic             busy,
  output logic [CNT_W-1:0] acc_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [7:0] DEPTH_L = 8'(DEPTH);

  state_t      state;
  logic        prio_load;
  logic        op_wr;
  logic        lat_ok;

  logic        pick_load;
  logic [6:0]  sel_addr;
  logic        sel_ok;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    pick_load = load_req && (!fetch_req || prio_load);
    sel_addr  = pick_load ? load_addr : fetch_addr;
    sel_ok    = ({1'b0, sel_addr} < DEPTH_L);
  end

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prio_load   <= 1'b0;
      op_wr       <= 1'b0;
      lat_ok      <= 1'b0;
      fetch_gnt   <= 1'b0;
      load_gnt    <= 1'b0;
      fetch_valid <= 1'b0;
      load_done   <= 1'b0;
      addr_err    <= 1'b0;
      fetch_data  <= '0;
      mem_addr    <= '0;
      mem_datain  <= '0;
      mem_sigwr   <= 1'b0;
      mem_sigon   <= 1'b0;
      acc_cnt     <= '0;
    end else begin
      fetch_gnt   <= 1'b0;
      load_gnt    <= 1'b0;
      fetch_valid <= 1'b0;
      load_done   <= 1'b0;
      addr_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_req || load_req) begin
            state     <= ACCESS;
            op_wr     <= pick_load;
            lat_ok    <= sel_ok;
            prio_load <= !pick_load;
            fetch_gnt <= !pick_load;
            load_gnt  <= pick_load;
            // Out-of-range accesses leave the memory port untouched.
            if (sel_ok) begin
              mem_sigon  <= 1'b1;
              mem_sigwr  <= pick_load;
              mem_addr   <= sel_addr;
              mem_datain <= pick_load ? load_data : 32'h0;
            end
          end
        end
        ACCESS: begin
          state       <= RESP;
          mem_sigon   <= 1'b0;
          mem_sigwr   <= 1'b0;
          fetch_valid <= !op_wr;
          load_done   <= op_wr;
          addr_err    <= !lat_ok;
          if (lat_ok && !op_wr) fetch_data <= mem_dataout;
          if (lat_ok) acc_cnt <= acc_cnt + CNT_W'(1);
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_insmem_arbiter.sv
// Self-checking bench for insmem_arbiter: behavioural memory, transaction model and
// a response scoreboard, run with a reduced depth and counter width.
module tb_insmem_arbiter;

  localparam int DEPTH = 64;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             fetch_req;
  logic [6:0]       fetch_addr;
  logic             fetch_gnt;
  logic             fetch_valid;
  logic [31:0]      fetch_data;
  logic             load_req;
  logic [6:0]       load_addr;
  logic [31:0]      load_data;
  logic             load_gnt;
  logic             load_done;
  logic             addr_err;
  logic [6:0]       mem_addr;
  logic [31:0]      mem_datain;
  logic             mem_sigwr;
  logic             mem_sigon;
  logic [31:0]      mem_dataout;
  logic             busy;
  logic [CNT_W-1:0] acc_cnt;

  insmem_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data),
    .load_gnt(load_gnt), .load_done(load_done), .addr_err(addr_err),
    .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_sigwr(mem_sigwr),
    .mem_sigon(mem_sigon), .mem_dataout(mem_dataout),
    .busy(busy), .acc_cnt(acc_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hA5A5_0000 ^ (32'(i) * 32'h0001_0101);
  endfunction

  // Level-enabled single-port memory; contents reload while reset is held.
  logic [31:0] mem [128];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) mem[i] <= init_word(i);
    end else if (mem_sigon && mem_sigwr) begin
      mem[mem_addr] <= mem_datain;
    end
  end
  assign mem_dataout = mem_sigon ? mem[mem_addr] : 32'h0;

  typedef struct {
    bit          wr;
    bit          err;
    logic [31:0] fdata;
    int          cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [128];
  logic [31:0] model_fdata;
  int          model_cnt;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void push_exp(input bit wr, input logic [6:0] a, input logic [31:0] d);
    exp_t e;
    e.wr  = wr;
    e.err = !(int'(a) < DEPTH);
    if (!e.err) begin
      if (wr) model_mem[a] = d;
      else    model_fdata = model_mem[a];
      model_cnt = (model_cnt + 1) % (1 << CNT_W);
    end
    e.fdata = model_fdata;
    e.cnt   = model_cnt;
    exp_q.push_back(e);
  endfunction

  // Scoreboard: every response pulse must match the oldest expected transaction.
  always @(negedge clk) begin
    if (rst_n && (fetch_valid || load_done)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'(fetch_valid | load_done), 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_kind", 32'(load_done), 32'(e.wr));
        check("resp_single", 32'(fetch_valid & load_done), 32'h0);
        check("resp_fdata", fetch_data, e.fdata);
        check("resp_err", 32'(addr_err), 32'(e.err));
        check("resp_cnt", 32'(acc_cnt), 32'(e.cnt));
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    model_cnt   = 0;
    model_fdata = 32'h0;
    for (int i = 0; i < 128; i++) model_mem[i] = init_word(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic single(input bit wr, input logic [6:0] a, input logic [31:0] d);
    bit inr;
    inr = (int'(a) < DEPTH);
    @(negedge clk);
    push_exp(wr, a, d);
    if (wr) begin
      load_req = 1'b1; load_addr = a; load_data = d;
    end else begin
      fetch_req = 1'b1; fetch_addr = a;
    end
    @(posedge clk); #1;
    check("acc_gnt", 32'(wr ? load_gnt : fetch_gnt), 32'h1);
    check("acc_other_gnt", 32'(wr ? fetch_gnt : load_gnt), 32'h0);
    check("acc_sigon", 32'(mem_sigon), 32'(inr));
    check("acc_busy", 32'(busy), 32'h1);
    if (inr) begin
      check("acc_addr", 32'(mem_addr), 32'(a));
      check("acc_sigwr", 32'(mem_sigwr), 32'(wr));
      check("acc_datain", mem_datain, wr ? d : 32'h0);
    end
    fetch_req = 1'b0;
    load_req  = 1'b0;
    @(posedge clk); #1;
    check("resp_sigon", 32'(mem_sigon), 32'h0);
    check("resp_pulse", 32'(wr ? load_done : fetch_valid), 32'h1);
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_pulse", 32'(fetch_valid | load_done), 32'h0);
  endtask

  task automatic wait_gnt(output int cyc, output bit got_load, output int busy_lo);
    bit found;
    found = 1'b0; cyc = 0; got_load = 1'b0; busy_lo = 0;
    while (!found && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
      if (!busy) busy_lo++;
      if (fetch_gnt || load_gnt) begin
        found    = 1'b1;
        got_load = load_gnt;
      end
    end
    if (!found) check("gnt_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int  cyc, blo;
    bit  gl;
    fetch_req = 1'b0; fetch_addr = '0;
    load_req  = 1'b0; load_addr  = '0; load_data = '0;
    do_reset();
    #1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_cnt", 32'(acc_cnt), 32'h0);
    check("rst_fdata", fetch_data, 32'h0);
    check("rst_sigon", 32'(mem_sigon), 32'h0);

    // Reset asserted in the middle of a write access.
    @(negedge clk);
    load_req = 1'b1; load_addr = 7'd5; load_data = 32'hCAFE_0005;
    @(posedge clk); #1;
    check("mid_sigon_before", 32'(mem_sigon), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_sigon", 32'(mem_sigon), 32'h0);
    check("mid_sigwr", 32'(mem_sigwr), 32'h0);
    check("mid_busy", 32'(busy), 32'h0);
    check("mid_cnt", 32'(acc_cnt), 32'h0);
    check("mid_gnt", 32'(load_gnt), 32'h0);
    check("mid_addr", 32'(mem_addr), 32'h0);
    load_req = 1'b0;
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    check("mid_after_busy", 32'(busy), 32'h0);
    check("mid_after_done", 32'(load_done), 32'h0);

    // Write then read back.
    single(1'b1, 7'h10, 32'hDEAD_BEEF);
    single(1'b0, 7'h10, 32'h0);
    check("wr_rd_data", fetch_data, 32'hDEAD_BEEF);
    check("wr_rd_cnt", 32'(acc_cnt), 32'h2);

    // Both requesters held high from reset alternate F, L, F, L.
    do_reset();
    @(negedge clk);
    push_exp(1'b0, 7'd3, 32'h0);
    push_exp(1'b1, 7'd4, 32'h1234_5678);
    push_exp(1'b0, 7'd3, 32'h0);
    push_exp(1'b1, 7'd4, 32'h1234_5678);
    fetch_req = 1'b1; fetch_addr = 7'd3;
    load_req  = 1'b1; load_addr  = 7'd4; load_data = 32'h1234_5678;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(cyc, gl, blo);
      check("arb_who", 32'(gl), 32'(k % 2));
      if (k == 0) check("arb_first_lat", 32'(cyc), 32'h1);
      else        check("arb_space", 32'(cyc), 32'h3);
      if (gl) check("arb_load_addr", 32'(mem_addr), 32'h4);
      else    check("arb_fetch_addr", 32'(mem_addr), 32'h3);
    end
    fetch_req = 1'b0;
    load_req  = 1'b0;
    repeat (3) @(posedge clk);

    // Out-of-range accesses: granted, flagged, memory untouched.
    single(1'b0, 7'h50, 32'h0);
    check("oor_fdata", fetch_data, model_fdata);
    single(1'b1, 7'h50, 32'hBAD0_BAD0);
    single(1'b0, 7'h10, 32'h0);
    check("oor_alias", fetch_data, init_word(16));

    // Counter wrap: 2-bit counter over five fetches.
    do_reset();
    for (int i = 0; i < 5; i++) single(1'b0, 7'(i), 32'h0);
    check("wrap_cnt", 32'(acc_cnt), 32'h1);

    // Fetch request held high continuously with a new address after each grant.
    @(negedge clk);
    fetch_addr = 7'd7;
    push_exp(1'b0, 7'd7, 32'h0);
    fetch_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(cyc, gl, blo);
      check("hold_who", 32'(gl), 32'h0);
      if (k > 0) begin
        check("hold_space", 32'(cyc), 32'h3);
        check("hold_busy_lo", 32'(blo), 32'h1);
      end
      if (k < 3) begin
        fetch_addr = 7'(8 + k);
        push_exp(1'b0, 7'(8 + k), 32'h0);
      end else begin
        fetch_req = 1'b0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    check("hold_last_data", fetch_data, init_word(10));
    check("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/insmem_arbiter.md
# insmem_arbiter

Arbiter and sequencer for the single-port, level-enabled 128x32 instruction memory of the multi-cycle processor. It shares the memory between the processor's instruction-fetch requester and the program-loader write requester. It drives the memory's address, data, write and enable controls through a fixed three-state access sequence and registers the read data. It also returns completion pulses, an address-error flag and a wrapping access counter.

## Interface
- DEPTH, 128, number of implemented words; addresses >= DEPTH are rejected
- CNT_W, 16, width of the access counter
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- fetch_req  in  1  fetch request; level, sampled in IDLE
- fetch_addr  in  7  fetch word address
- fetch_gnt  out  1  one-cycle pulse: fetch request accepted, address latched
- fetch_valid  out  1  one-cycle pulse: fetch_data holds the read word
- fetch_data  out  32  registered read data, held until the next fetch completes
- load_req  in  1  loader write request; level, sampled in IDLE
- load_addr  in  7  loader word address
- load_data  in  32  loader write data
- load_gnt  out  1  one-cycle pulse: write accepted, address and data latched
- load_done  out  1  one-cycle pulse: write completed
- addr_err  out  1  one-cycle pulse with fetch_valid or load_done: address was >= DEPTH
- mem_addr  out  7  to memory addr
- mem_datain  out  32  to memory datain
- mem_sigwr  out  1  to memory sigwr
- mem_sigon  out  1  to memory sigon
- mem_dataout  in  32  from memory dataout
- busy  out  1  high whenever state != IDLE
- acc_cnt  out  CNT_W  count of completed in-range accesses, wraps

## Operation
- States are IDLE, ACCESS and RESP. The reset state is IDLE.
- **IDLE, no request:** remain in IDLE.
- **IDLE, any request:** select one requester, latch its address (and data for a load), record op = read or write, then go to ACCESS.
- **Arbitration:** round-robin flag prio_load, reset 0.
  - Only one requester high: that requester wins.
  - Both high: load wins if prio_load = 1, otherwise fetch wins.
  - After each grant, prio_load is set to 1 if fetch was granted and to 0 if load was granted.
- **ACCESS, address in range:**
  - mem_sigon = 1 and mem_addr = latched address.
  - For a write: mem_sigwr = 1 and mem_datain = latched data.
  - For a read: mem_sigwr = 0 and mem_datain = 0.
  - The matching gnt pulse is high in this cycle.
- **ACCESS, address >= DEPTH:** mem_sigon stays 0 and the memory is not touched. The gnt pulse is still issued.
- **ACCESS to RESP transition:** on the edge leaving ACCESS, for an in-range read, fetch_data <= mem_dataout.
- **RESP:**
  - mem_sigon = 0 and mem_sigwr = 0; mem_addr holds its value.
  - fetch_valid or load_done pulses, with addr_err if applicable.
  - acc_cnt increments only for in-range accesses; it wraps from 2^CNT_W-1 to 0.
  - Next state is IDLE.
- **Request hold:** requesters may drop req in the cycle after gnt. A req still high in IDLE is treated as a new request.
- **Reset values (also asserted asynchronously mid-operation):**
  - Go to IDLE and clear prio_load.
  - All pulses, busy, mem_sigon and mem_sigwr go to 0.
  - mem_addr, mem_datain, fetch_data and acc_cnt go to 0.
  - An interrupted access returns no response and is not counted.
- **Outputs:** every output is driven from registers or decoded from the state register only, with no combinational path from req inputs.

## Timing
- Request high at edge E (state IDLE):
  - ACCESS during cycle E+1; gnt is high and the memory is enabled.
  - RESP during cycle E+2; valid/done is high and fetch_data is updated.
  - IDLE at E+3.
- Latency from request sample to response pulse is 2 cycles. Maximum throughput is one access per 3 cycles.
- mem_sigon is high for exactly one cycle per in-range access. The memory address and data are stable for that whole cycle.
- Back-to-back requests with both requesters held high alternate F, L, F, L… The minimum spacing between grants is 3 cycles.
- A request arriving during ACCESS or RESP is not seen until IDLE.

## Test plan
- **Reset:** assert rst_n = 0 mid-ACCESS of a write to addr 5 -> same cycle: mem_sigon = 0, busy = 0, acc_cnt = 0. After release the controller sits idle with no done pulse.
- **Write then read:** load addr 0x10 with data 0xDEADBEEF -> load_gnt at E+1 with mem_sigwr = 1, mem_addr = 0x10; load_done at E+2. Then fetch 0x10 -> fetch_valid 2 cycles after sample with fetch_data = 0xDEADBEEF; acc_cnt = 2.
- **Simultaneous requests:** fetch addr 3 and load addr 4 both high from reset -> grants in order fetch(3), load(4), fetch(3), load(4) at 3-cycle spacing.
- **Out of range:** run with DEPTH = 64, fetch addr 0x50 -> fetch_gnt issued, mem_sigon never high, fetch_valid with addr_err = 1, fetch_data unchanged, acc_cnt unchanged.
- **Counter wrap:** run with CNT_W = 2 and 5 fetches -> acc_cnt sequence 1, 2, 3, 0, 1.
- **Held request:** keep fetch_req high continuously -> fetch_gnt every 3 cycles, busy low exactly one cycle in every three, fetch_data updated on each fetch_valid.
